axis_bram_read_arbiter: RTL
===========================

AXIS_BRAM_READ_ARBITER -- requirements
Module: axis_bram_read_arbiter

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, output stream data width.
REQ-002 The block SHALL have parameter BRAM_DATA_WIDTH, default 32, BRAM read data width; it equals AXIS_TDATA_WIDTH.
REQ-003 The block SHALL have parameter BRAM_ADDR_WIDTH, default 14, BRAM address width.
REQ-004 The block SHALL have port aclk, input, 1, the single clock.
REQ-005 The block SHALL have port aresetn, input, 1, reset: asynchronous assert, active-low.
REQ-006 The block SHALL have ports req0_start and req1_start, input, 1 each, one-cycle burst request pulses.
REQ-007 The block SHALL have ports cfg0_addr and cfg1_addr, input, BRAM_ADDR_WIDTH each, burst start address.
REQ-008 The block SHALL have ports cfg0_len and cfg1_len, input, BRAM_ADDR_WIDTH each, burst word count minus one.
REQ-009 The block SHALL have ports done0 and done1, output, 1 each, one-cycle pulse when that channel's last beat is accepted.
REQ-010 The block SHALL have port sts_busy, output, 1, high when the state is not IDLE.
REQ-011 The block SHALL have ports m_axis_tready (in, 1), m_axis_tdata (out, AXIS_TDATA_WIDTH), m_axis_tvalid (out, 1), m_axis_tlast (out, 1) and m_axis_tuser (out, 1, granted channel index).
REQ-012 The block SHALL have ports bram_porta_clk (out, 1), bram_porta_rst (out, 1), bram_porta_addr (out, BRAM_ADDR_WIDTH), bram_porta_rddata (in, BRAM_DATA_WIDTH) and bram_porta_we (out, 1).

Function
REQ-013 The block SHALL set a per-channel pending flag on reqN_start; a start while that channel is already pending SHALL be ignored.
REQ-014 A start for the channel currently streaming SHALL set its pending flag, so the channel is served again after the current burst.
REQ-015 The FSM SHALL have states IDLE, PRIME and STREAM.
REQ-016 In IDLE with any flag pending, the FSM SHALL select a grant and go to PRIME in one cycle.
REQ-017 The grant SHALL be round-robin: with both pending, the channel not served last wins; the last-served pointer resets to 1, so channel 0 wins first.
REQ-018 On grant, the block SHALL latch cfgN_addr and cfgN_len into base and length registers, clear the pending flag, zero the beat counter and set tuser.
REQ-019 Configuration inputs SHALL be ignored except on the grant cycle.
REQ-020 PRIME SHALL last exactly one cycle with bram_porta_addr = base, covering the one-cycle BRAM read latency; the FSM then goes to STREAM.
REQ-021 In STREAM, m_axis_tvalid SHALL be 1 and m_axis_tdata SHALL equal bram_porta_rddata.
REQ-022 In STREAM, bram_porta_addr SHALL be base+cnt+1 when m_axis_tready is high, else base+cnt, so that data for the next beat is valid one cycle later.
REQ-023 All address sums SHALL be computed modulo 2^BRAM_ADDR_WIDTH, so bursts wrap past the top of memory.
REQ-024 m_axis_tlast SHALL be high when tvalid is high and cnt == length.
REQ-025 On a tlast handshake, the block SHALL pulse doneN and go to IDLE; the next grant is decided in IDLE, giving a minimum 2-cycle gap between bursts.
REQ-026 A burst SHALL NOT be preempted, and tdata, tlast and tuser SHALL hold stable while tvalid is high and tready is low.
REQ-027 cfg_len = 0 SHALL give a one-beat burst with tlast on that beat; cfg_len = 2^W-1 SHALL give 2^W beats.
REQ-028 In IDLE and PRIME, bram_porta_addr SHALL be base, tvalid SHALL be 0 and tlast SHALL be 0.
REQ-029 bram_porta_clk SHALL equal aclk, bram_porta_rst SHALL equal ~aresetn, and bram_porta_we SHALL be 0.

Reset
REQ-030 While aresetn is low, the FSM SHALL be IDLE and the pending flags, cnt, base, length, tuser and done0/done1 SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL drop tvalid immediately and discard all pending requests.
REQ-032 After reset release, the block SHALL need one new start pulse before it issues a grant.

Structure
REQ-033 The FSM state encodings SHALL be in a shared package; the block SHALL use no other typedefs.
REQ-034 The round-robin grant logic SHALL be a sub-module rr_arbiter2 with inputs req[1:0] and last and output grant.

Verification
REQ-035 Single burst: cfg0_addr=0x10, cfg0_len=3, req0 pulse, tready=1 -> addresses 0x10..0x13 on 4 consecutive beats, tlast on the 4th beat, done0 pulse, tuser=0.
REQ-036 Contention: req0 and req1 pulsed in the same cycle -> channel 0 burst first, then channel 1; re-pulse both -> channel 0 first again, because the pointer alternates.
REQ-037 Backpressure: len=7, tready toggled 1,0,0,1 repeatedly -> 8 beats in order, no beat duplicated or skipped, tdata held stable while stalled.
REQ-038 Wrap: cfg1_addr=0x3FFE, len=3 (W=14) -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-039 Boundary: len=0 -> one beat with tlast; req0 re-pulsed mid-burst -> second channel 0 burst after IDLE; duplicate pulse while pending -> only one burst.
REQ-040 Reset mid-burst: aresetn low at beat 2 -> tvalid=0 in the same cycle, sts_busy=0, no done pulse, and a pending req1 is discarded.

Source files
------------

// File: rtl/axis_bram_read_arbiter_pkg.sv
// Shared definitions for the two-channel BRAM-to-AXI-Stream read arbiter.
// Holds the FSM state encoding and the reset value of the round-robin pointer.
package axis_bram_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Pointer starts at channel 1 so channel 0 wins the first contention.
  localparam logic LAST_RESET = 1'b1;

endpackage

// File: rtl/axis_bram_read_arbiter_if.sv
// AXI-Stream master bundle produced by the arbiter.
// Signals: tready (sink -> source), tdata, tvalid, tlast, tuser (granted channel).
// Modports: master (the arbiter), slave (the downstream sink).
interface axis_bram_read_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tuser;

  modport master (input tready, output tdata, output tvalid, output tlast, output tuser);
  modport slave  (output tready, input tdata, input tvalid, input tlast, input tuser);
endinterface

// File: rtl/axis_bram_read_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant selection.
// Ports: req[1:0] pending requests, last = channel served most recently,
//        grant = selected channel index (meaningful only when req != 0).
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (&req) grant = ~last;
    else      grant = req[1];
  end

endmodule

// File: rtl/axis_bram_read_arbiter.sv
// Two-channel burst reader: each channel requests a burst of consecutive BRAM
// words, bursts are granted round-robin and streamed out on one AXI-Stream port.
// Ports: aclk/aresetn (async active-low), reqN_start pulses, cfgN_addr/cfgN_len
//        (burst start address / word count minus one), doneN pulses, sts_busy,
//        m_axis stream master, bram_porta_* read port (one-cycle read latency).
//
// state     | meaning
// ----------|---------------------------------------------------------------
// ST_IDLE   | no burst; grant decided here when any channel is pending
// ST_PRIME  | address = base presented, waiting for BRAM read latency
// ST_STREAM | beats valid; address runs one word ahead of accepted beats
module axis_bram_read_arbiter
  import axis_bram_read_arbiter_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 14
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        req0_start,
  input  logic                        req1_start,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg0_addr,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg1_addr,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg0_len,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg1_len,
  output logic                        done0,
  output logic                        done1,
  output logic                        sts_busy,
  axis_bram_read_arbiter_if.master    m_axis,
  output logic                        bram_porta_clk,
  output logic                        bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]  bram_porta_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  bram_porta_rddata,
  output logic                        bram_porta_we
);

  state_t                     state, state_nxt;
  logic [1:0]                 pend, pend_nxt;
  logic [BRAM_ADDR_WIDTH-1:0] base, len, cnt;
  logic                       tuser_r, last_r;
  logic                       grant, grant_fire;
  logic                       beat_ok, last_beat, burst_end;

  rr_arbiter2 u_rr (
    .req   (pend),
    .last  (last_r),
    .grant (grant)
  );

  assign beat_ok   = (state == ST_STREAM) && m_axis.tready;
  assign last_beat = (cnt == len);
  assign burst_end = beat_ok && last_beat;

  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|pend) begin
          grant_fire = 1'b1;
          state_nxt  = ST_PRIME;
        end
      end
      ST_PRIME:  state_nxt = ST_STREAM;
      ST_STREAM: if (burst_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // A start for an already-pending channel is a no-op; the granted channel's
  // flag is pending by construction, so clearing it also swallows such a start.
  always_comb begin
    pend_nxt = pend | {req1_start, req0_start};
    if (grant_fire) pend_nxt[grant] = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pend    <= 2'b00;
      base    <= '0;
      len     <= '0;
      cnt     <= '0;
      tuser_r <= 1'b0;
      last_r  <= LAST_RESET;
    end else begin
      pend <= pend_nxt;
      if (grant_fire) begin
        base    <= grant ? cfg1_addr : cfg0_addr;
        len     <= grant ? cfg1_len  : cfg0_len;
        cnt     <= '0;
        tuser_r <= grant;
        last_r  <= grant;
      end else if (beat_ok && !last_beat) begin
        cnt <= cnt + BRAM_ADDR_WIDTH'(1);
      end
    end
  end

  // Prefetch: when the current beat is accepted, fetch the next word now so it
  // appears on rddata at the next edge. Sums wrap naturally at the address width.
  always_comb begin
    bram_porta_addr = base;
    if (state == ST_STREAM)
      bram_porta_addr = base + cnt + BRAM_ADDR_WIDTH'(m_axis.tready);
  end

  assign m_axis.tvalid = (state == ST_STREAM);
  assign m_axis.tlast  = (state == ST_STREAM) && last_beat;
  assign m_axis.tdata  = bram_porta_rddata;
  assign m_axis.tuser  = tuser_r;

  assign done0    = burst_end && !tuser_r;
  assign done1    = burst_end &&  tuser_r;
  assign sts_busy = (state != ST_IDLE);

  assign bram_porta_clk = aclk;
  assign bram_porta_rst = ~aresetn;
  assign bram_porta_we  = 1'b0;

endmodule
